or1k_branch_resolve: RTL and testbench

//  Execute-stage partner of the gshare predictor: registers the decode-stage conditional branch
//  (bf/bnf, PC, target, predicted flag), resolves it against the real SR[F], and flags mispredicts.

---
 rtl/or1k_pkg.sv | 12 +
 rtl/or1k_sat_counter.sv | 23 ++
 rtl/or1k_branch_resolve.sv | 151 +++++++++++++++
 tb/tb_or1k_branch_resolve.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_pkg.sv
// Shared types and constants for the conditional-branch resolution slice.
package or1k_pkg;

    typedef enum logic {
        BR_IDLE     = 1'b0,
        BR_REDIRECT = 1'b1
    } br_state_t;

    // Fetch restarts past the delay slot when a branch resolves not-taken.
    localparam int unsigned DELAY_SLOT_OFFSET = 8;

endpackage

// File: rtl/or1k_sat_counter.sv
// Saturating event counter with a synchronous clear that beats an increment.
module or1k_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up, stick at all-ones, clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/or1k_branch_resolve.sv
// Execute-stage conditional branch resolution: mispredict detection, fetch
// redirect handshake and branch statistics for the gshare predictor.
module or1k_branch_resolve
    import or1k_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned STAT_WIDTH           = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic                            padv_execute_i,
    input  logic                            pipeline_flush_i,
    input  logic                            decode_op_bf_i,
    input  logic                            decode_op_bnf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i,
    input  logic                            predicted_flag_i,
    input  logic                            flag_i,
    input  logic                            flag_valid_i,
    output logic                            execute_op_bf_o,
    output logic                            execute_op_bnf_o,
    output logic                            prev_op_brcond_o,
    output logic                            branch_mispredict_o,
    output logic                            redirect_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    input  logic                            redirect_ready_i,
    output logic                            decode_stall_o,
    input  logic                            stat_clear_i,
    output logic [STAT_WIDTH-1:0]           stat_branches_o,
    output logic [STAT_WIDTH-1:0]           stat_mispredicts_o
);

    localparam int unsigned OW = OPTION_OPERAND_WIDTH;

    br_state_t       state;
    logic            exec_valid;
    logic            exec_bf;
    logic            exec_bnf;
    logic            exec_pred;
    logic [OW-1:0]   exec_pc;
    logic [OW-1:0]   exec_target;

    logic            resolving_c;
    logic            retire_c;
    logic            taken_c;
    logic            mispredict_c;
    logic            capture_c;

    // Resolution happens only with a settled flag, an advancing execute stage
    // and no redirect outstanding; a flush kills its side effects.
    assign resolving_c  = exec_valid & flag_valid_i & padv_execute_i & (state == BR_IDLE);
    assign retire_c     = resolving_c & ~pipeline_flush_i;
    assign taken_c      = exec_bf ? flag_i : ~flag_i;
    assign mispredict_c = (taken_c != exec_pred);
    assign capture_c    = padv_decode_i & ~decode_stall_o;

    // Decode may only proceed when the execute slot is free or draining now.
    assign decode_stall_o = (exec_valid & ~resolving_c) | (state == BR_REDIRECT);

    assign prev_op_brcond_o = exec_valid;
    assign execute_op_bf_o  = exec_bf;
    assign execute_op_bnf_o = exec_bnf;

    // Execute-slot entry: capture from decode, retire on resolve, kill on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_valid  <= 1'b0;
            exec_bf     <= 1'b0;
            exec_bnf    <= 1'b0;
            exec_pred   <= 1'b0;
            exec_pc     <= '0;
            exec_target <= '0;
        end else if (pipeline_flush_i) begin
            exec_valid <= 1'b0;
            exec_bf    <= 1'b0;
            exec_bnf   <= 1'b0;
        end else if (capture_c) begin
            // bf and bnf together is illegal; treat it as bf.
            exec_valid  <= decode_op_bf_i | decode_op_bnf_i;
            exec_bf     <= decode_op_bf_i;
            exec_bnf    <= decode_op_bnf_i & ~decode_op_bf_i;
            exec_pred   <= predicted_flag_i;
            exec_pc     <= decode_pc_i;
            exec_target <= decode_target_i;
        end else if (resolving_c) begin
            exec_valid <= 1'b0;
            exec_bf    <= 1'b0;
            exec_bnf   <= 1'b0;
        end
    end

    // Redirect FSM with registered mispredict pulse and redirect handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= BR_IDLE;
            redirect_valid_o    <= 1'b0;
            redirect_pc_o       <= '0;
            branch_mispredict_o <= 1'b0;
        end else begin
            branch_mispredict_o <= retire_c & mispredict_c;
            if (retire_c) begin
                redirect_pc_o <= taken_c ? exec_target : exec_pc + OW'(DELAY_SLOT_OFFSET);
            end
            if (pipeline_flush_i) begin
                state            <= BR_IDLE;
                redirect_valid_o <= 1'b0;
            end else begin
                case (state)
                    BR_IDLE: begin
                        if (retire_c && mispredict_c) begin
                            state            <= BR_REDIRECT;
                            redirect_valid_o <= 1'b1;
                        end
                    end
                    BR_REDIRECT: begin
                        if (redirect_ready_i) begin
                            state            <= BR_IDLE;
                            redirect_valid_o <= 1'b0;
                        end
                    end
                    default: begin
                        state            <= BR_IDLE;
                        redirect_valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    or1k_sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat_branches (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_c),
        .clr   (stat_clear_i),
        .count (stat_branches_o)
    );

    or1k_sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_c & mispredict_c),
        .clr   (stat_clear_i),
        .count (stat_mispredicts_o)
    );

endmodule

// File: tb/tb_or1k_branch_resolve.sv
// Directed bench for or1k_branch_resolve: vector table of single branches plus
// hand sequences for redirect hold, flush, stat clear and async reset.
module tb_or1k_branch_resolve;

    logic        clk;
    logic        rst;
    logic        padv_decode;
    logic        padv_execute;
    logic        pipeline_flush;
    logic        decode_op_bf;
    logic        decode_op_bnf;
    logic [31:0] decode_pc;
    logic [31:0] decode_target;
    logic        predicted_flag;
    logic        flag;
    logic        flag_valid;
    logic        redirect_ready;
    logic        stat_clear;

    logic        execute_op_bf;
    logic        execute_op_bnf;
    logic        prev_op_brcond;
    logic        branch_mispredict;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        decode_stall;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    // Narrow-counter instance sharing the same stimulus to reach saturation.
    logic        s_bf, s_bnf, s_brcond, s_mis, s_rv, s_stall;
    logic [31:0] s_rpc;
    logic [2:0]  s_branches;
    logic [2:0]  s_mispredicts;

    int total = 0;
    int bad   = 0;
    int model_br  = 0;
    int model_mis = 0;

    or1k_branch_resolve #(.OPTION_OPERAND_WIDTH(32), .STAT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .padv_decode_i(padv_decode), .padv_execute_i(padv_execute),
        .pipeline_flush_i(pipeline_flush),
        .decode_op_bf_i(decode_op_bf), .decode_op_bnf_i(decode_op_bnf),
        .decode_pc_i(decode_pc), .decode_target_i(decode_target),
        .predicted_flag_i(predicted_flag), .flag_i(flag), .flag_valid_i(flag_valid),
        .execute_op_bf_o(execute_op_bf), .execute_op_bnf_o(execute_op_bnf),
        .prev_op_brcond_o(prev_op_brcond), .branch_mispredict_o(branch_mispredict),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .redirect_ready_i(redirect_ready), .decode_stall_o(decode_stall),
        .stat_clear_i(stat_clear),
        .stat_branches_o(stat_branches), .stat_mispredicts_o(stat_mispredicts)
    );

    or1k_branch_resolve #(.OPTION_OPERAND_WIDTH(32), .STAT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst),
        .padv_decode_i(padv_decode), .padv_execute_i(padv_execute),
        .pipeline_flush_i(pipeline_flush),
        .decode_op_bf_i(decode_op_bf), .decode_op_bnf_i(decode_op_bnf),
        .decode_pc_i(decode_pc), .decode_target_i(decode_target),
        .predicted_flag_i(predicted_flag), .flag_i(flag), .flag_valid_i(flag_valid),
        .execute_op_bf_o(s_bf), .execute_op_bnf_o(s_bnf),
        .prev_op_brcond_o(s_brcond), .branch_mispredict_o(s_mis),
        .redirect_valid_o(s_rv), .redirect_pc_o(s_rpc),
        .redirect_ready_i(redirect_ready), .decode_stall_o(s_stall),
        .stat_clear_i(stat_clear),
        .stat_branches_o(s_branches), .stat_mispredicts_o(s_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        bf;
        logic        bnf;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic        flg;
        logic        exp_bf;
        logic        exp_bnf;
        logic        exp_mis;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, " branches"},    32'(stat_branches),    32'(model_br));
        check({tag, " mispredicts"}, 32'(stat_mispredicts), 32'(model_mis));
        check({tag, " sat branches"},    32'(s_branches),    32'(model_br  > 7 ? 7 : model_br));
        check({tag, " sat mispredicts"}, 32'(s_mispredicts), 32'(model_mis > 7 ? 7 : model_mis));
    endtask

    // Capture one branch, resolve it (optionally with flush / stat clear), drain.
    task automatic run_vector(input vec_t v, input logic flush, input logic clr, input string tag);
        logic exp_mis;
        exp_mis = v.exp_mis & ~flush;
        padv_decode    = 1'b1;
        decode_op_bf   = v.bf;
        decode_op_bnf  = v.bnf;
        decode_pc      = v.pc;
        decode_target  = v.target;
        predicted_flag = v.pred;
        padv_execute   = 1'b0;
        flag_valid     = 1'b0;
        #1;
        check({tag, " stall idle"}, 32'(decode_stall), 32'd0);
        tick();
        padv_decode   = 1'b0;
        decode_op_bf  = 1'b0;
        decode_op_bnf = 1'b0;
        check({tag, " brcond"}, 32'(prev_op_brcond), 32'd1);
        check({tag, " exec bf"}, 32'(execute_op_bf), 32'(v.exp_bf));
        check({tag, " exec bnf"}, 32'(execute_op_bnf), 32'(v.exp_bnf));
        check({tag, " stall pending"}, 32'(decode_stall), 32'd1);
        flag           = v.flg;
        flag_valid     = 1'b1;
        padv_execute   = 1'b1;
        pipeline_flush = flush;
        stat_clear     = clr;
        #1;
        check({tag, " stall resolving"}, 32'(decode_stall), 32'd0);
        tick();
        flag_valid     = 1'b0;
        padv_execute   = 1'b0;
        pipeline_flush = 1'b0;
        stat_clear     = 1'b0;
        if (clr) begin
            model_br  = 0;
            model_mis = 0;
        end else if (!flush) begin
            model_br++;
            if (v.exp_mis) model_mis++;
        end
        check({tag, " mispredict pulse"}, 32'(branch_mispredict), 32'(exp_mis));
        check({tag, " redirect valid"}, 32'(redirect_valid), 32'(exp_mis));
        check({tag, " brcond cleared"}, 32'(prev_op_brcond), 32'd0);
        check_stats(tag);
        if (exp_mis) begin
            check({tag, " redirect pc"}, redirect_pc, v.exp_pc);
            check({tag, " stall redirect"}, 32'(decode_stall), 32'd1);
            redirect_ready = 1'b1;
            tick();
            redirect_ready = 1'b0;
        end else begin
            tick();
        end
        check({tag, " pulse one cycle"}, 32'(branch_mispredict), 32'd0);
        check({tag, " redirect dropped"}, 32'(redirect_valid), 32'd0);
        check({tag, " stall released"}, 32'(decode_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        padv_decode = 1'b0; padv_execute = 1'b0; pipeline_flush = 1'b0;
        decode_op_bf = 1'b0; decode_op_bnf = 1'b0;
        decode_pc = '0; decode_target = '0; predicted_flag = 1'b0;
        flag = 1'b0; flag_valid = 1'b0; redirect_ready = 1'b0; stat_clear = 1'b0;

        //           bf    bnf   pc            target        pred  flg   xbf   xbnf  xmis  xpc
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0108};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0400, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0500, 32'h0000_0600, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0700, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0800};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0900, 32'h0000_0A00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0A00};

        repeat (2) @(posedge clk);
        #1;
        check("reset mispredict", 32'(branch_mispredict), 32'd0);
        check("reset redirect valid", 32'(redirect_valid), 32'd0);
        check("reset redirect pc", redirect_pc, 32'd0);
        check("reset brcond", 32'(prev_op_brcond), 32'd0);
        check("reset stall", 32'(decode_stall), 32'd0);
        check_stats("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vector(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Redirect held while fetch is not ready.
        padv_decode = 1'b1; decode_op_bf = 1'b1; decode_op_bnf = 1'b0;
        decode_pc = 32'h0000_0300; decode_target = 32'h0000_0400; predicted_flag = 1'b0;
        tick();
        padv_decode = 1'b0; decode_op_bf = 1'b0;
        flag = 1'b1; flag_valid = 1'b1; padv_execute = 1'b1;
        tick();
        flag_valid = 1'b0; padv_execute = 1'b0;
        model_br++; model_mis++;
        check("hold pulse", 32'(branch_mispredict), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold valid c%0d", i), 32'(redirect_valid), 32'd1);
            check($sformatf("hold pc c%0d", i), redirect_pc, 32'h0000_0400);
            check($sformatf("hold stall c%0d", i), 32'(decode_stall), 32'd1);
            tick();
        end
        check("hold pulse gone", 32'(branch_mispredict), 32'd0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("hold released", 32'(redirect_valid), 32'd0);
        check_stats("hold");

        // Mispredict resolved in the same cycle as a flush.
        run_vector(vecs[1], 1'b1, 1'b0, "flush");

        // Stat clear coinciding with an increment.
        run_vector(vecs[2], 1'b0, 1'b1, "clear");

        // Async reset while a redirect is pending.
        padv_decode = 1'b1; decode_op_bnf = 1'b1;
        decode_pc = 32'h0000_0100; decode_target = 32'h0000_0200; predicted_flag = 1'b1;
        tick();
        padv_decode = 1'b0; decode_op_bnf = 1'b0;
        flag = 1'b1; flag_valid = 1'b1; padv_execute = 1'b1;
        tick();
        flag_valid = 1'b0; padv_execute = 1'b0;
        model_br++; model_mis++;
        check("pre-reset redirect", 32'(redirect_valid), 32'd1);
        check_stats("pre-reset");
        #2 rst = 1'b0;
        #1;
        model_br = 0; model_mis = 0;
        check("async reset redirect", 32'(redirect_valid), 32'd0);
        check("async reset pc", redirect_pc, 32'd0);
        check("async reset stall", 32'(decode_stall), 32'd0);
        check_stats("async reset");
        rst = 1'b1;
        tick();
        check("post-reset redirect", 32'(redirect_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
